// File: rtl/instr_sequencer_if.sv
// Host-side bundle for instr_sequencer: program load port, run controls and
// the Instruction/Run stream presented to proc.
interface instr_sequencer_if #(
  parameter int IW     = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int HOLD_W = 8
);
  logic              Load_en;
  logic [AW-1:0]     Load_addr;
  logic [IW-1:0]     Load_data;
  logic [AW:0]       Count;
  logic [HOLD_W-1:0] Hold;
  logic              Loop;
  logic              Start;
  logic              Stop;
  logic [IW-1:0]     Instruction;
  logic              Run;
  logic [AW-1:0]     PC;
  logic              Busy;
  logic              Done;

  modport master (
    output Load_en, Load_addr, Load_data, Count, Hold, Loop, Start, Stop,
    input  Instruction, Run, PC, Busy, Done
  );

  modport slave (
    input  Load_en, Load_addr, Load_data, Count, Hold, Loop, Start, Stop,
    output Instruction, Run, PC, Busy, Done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction stimulus engine: plays a loaded program into proc, each entry
// held for a programmable number of cycles. INSTR_SEQ_LOOP_EN enables Loop.
module instr_sequencer #(
  parameter int IW     = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int HOLD_W = 8
) (
  input logic              CLOCK_50,
  input logic              Resetn,
  instr_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [AW-1:0]     pc_reg, pc_next;
  logic [HOLD_W-1:0] timer_reg, timer_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [AW:0]       count_reg, count_next;
  logic              loop_active;
  logic              can_start;

  logic [IW-1:0] mem [DEPTH];

`ifdef INSTR_SEQ_LOOP_EN
  assign loop_active = bus.Loop;
`else
  logic unused_loop;
  assign unused_loop = bus.Loop;
  assign loop_active = 1'b0;
`endif

  // Program store is never reset; the sequence reads it combinationally.
  always_ff @(posedge CLOCK_50) begin
    if (bus.Load_en && (state_reg != ACTIVE)) begin
      mem[bus.Load_addr] <= bus.Load_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      timer_reg <= '0;
      hold_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      timer_reg <= timer_next;
      hold_reg  <= hold_next;
      count_reg <= count_next;
    end
  end

  assign can_start = bus.Start && (bus.Count != '0);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    timer_next = timer_reg;
    hold_next  = hold_reg;
    count_next = count_reg;
    if (bus.Stop) begin
      state_next = IDLE;
      pc_next    = '0;
      timer_next = '0;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (can_start) begin
            count_next = (bus.Count > DEPTH_C) ? DEPTH_C : bus.Count;
            hold_next  = (bus.Hold == '0) ? HOLD_W'(1) : bus.Hold;
            pc_next    = '0;
            timer_next = '0;
            state_next = ACTIVE;
          end
        end
        ACTIVE: begin
          if (timer_reg == hold_reg - 1'b1) begin
            timer_next = '0;
            if ({1'b0, pc_reg} != count_reg - 1'b1) begin
              pc_next = pc_reg + 1'b1;
            end else if (loop_active) begin
              pc_next = '0;
            end else begin
              state_next = DONE;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.Instruction = (state_reg == ACTIVE) ? mem[pc_reg] : '0;
  assign bus.Run         = (state_reg == ACTIVE);
  assign bus.Busy        = (state_reg == ACTIVE);
  assign bus.Done        = (state_reg == DONE);
  assign bus.PC          = pc_reg;
endmodule
